// File: rtl/xor_stream_descrambler_pkg.sv
// Shared definitions for the 8-bit XOR scrambling path (transmit scrambler and
// receive descrambler). Keeping the keystream constants here makes both ends
// generate identical keystreams.
package xor_stream_descrambler_pkg;

  localparam int unsigned LFSR_WIDTH = 16;

  // Galois feedback mask and power-on / zero-seed substitute value.
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_POLY = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    StRun    = 1'b0,
    StResync = 1'b1
  } state_e;

endpackage

// File: rtl/xor_stream_descrambler_lfsr_step8.sv
// Combinational keystream advance: applies STEPS Galois LFSR steps to the
// current state. Shared with the transmit scrambler so both ends stay
// bit-identical.
//
// Ports:
//   i_lfsr  current LFSR state
//   o_lfsr  LFSR state after STEPS steps
module xor_stream_descrambler_lfsr_step8 #(
  parameter int unsigned            LFSR_WIDTH = 16,
  parameter int unsigned            STEPS      = 8,
  parameter logic [LFSR_WIDTH-1:0]  POLY       = 16'hB400
) (
  input  logic [LFSR_WIDTH-1:0] i_lfsr,
  output logic [LFSR_WIDTH-1:0] o_lfsr
);

  logic [LFSR_WIDTH-1:0] w_s;

  // Unrolled: each iteration shifts out bit 0 and folds it back via POLY.
  always_comb begin
    w_s = i_lfsr;
    for (int i = 0; i < STEPS; i++) begin
      if (w_s[0]) begin
        w_s = (w_s >> 1) ^ POLY;
      end else begin
        w_s = w_s >> 1;
      end
    end
    o_lfsr = w_s;
  end

endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR stream descrambler. Regenerates the transmitter keystream
// with a Galois LFSR and XORs it onto incoming scrambled bytes. Valid/ready on
// both sides, one output register stage, seed resynchronisation and an
// accepted-byte counter.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_seed_load   one-cycle pulse: load i_seed, drop held output, clear count
//   i_seed        new LFSR value (zero is replaced by SEED_DEFAULT)
//   i_s_valid     scrambled byte present
//   o_s_ready     block can accept a byte this cycle
//   i_s_data      scrambled byte
//   o_m_valid     plaintext byte present
//   i_m_ready     consumer accepts a byte
//   o_m_data      recovered plaintext byte
//   o_byte_count  bytes accepted since last reset or seed load (wraps)
module xor_stream_descrambler #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] POLY         = xor_stream_descrambler_pkg::DEFAULT_POLY,
  parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = xor_stream_descrambler_pkg::DEFAULT_SEED,
  parameter int unsigned           CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_seed_load,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [CNT_WIDTH-1:0]  o_byte_count
);

  import xor_stream_descrambler_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [LFSR_WIDTH-1:0] w_lfsr_next;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_s_ready;
  logic                  w_xfer;

  xor_stream_descrambler_lfsr_step8 #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .STEPS      (DATA_WIDTH),
    .POLY       (POLY)
  ) u_step (
    .i_lfsr (r_lfsr),
    .o_lfsr (w_lfsr_next)
  );

  // seed_load takes priority over a transfer, so the sender must hold its byte.
  assign w_s_ready = !i_reset && (r_state == StRun) && !i_seed_load &&
                     (!r_m_valid || i_m_ready);
  assign w_xfer    = i_s_valid && w_s_ready;

  // A seed load in either state (re)enters RESYNC for one cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:    w_state_next = i_seed_load ? StResync : StRun;
      StResync: w_state_next = i_seed_load ? StResync : StRun;
      default:  w_state_next = StRun;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StRun;
      r_lfsr    <= SEED_DEFAULT;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_seed_load) begin
        // Zero seed would lock the LFSR; substitute the default.
        r_lfsr    <= (i_seed == '0) ? SEED_DEFAULT : i_seed;
        r_m_valid <= 1'b0;
        r_count   <= '0;
      end else if (w_xfer) begin
        r_m_data  <= i_s_data ^ r_lfsr[DATA_WIDTH-1:0];
        r_m_valid <= 1'b1;
        r_lfsr    <= w_lfsr_next;
        r_count   <= r_count + 1'b1;
      end else if (i_m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_s_ready    = w_s_ready;
  assign o_m_valid    = r_m_valid;
  assign o_m_data     = r_m_data;
  assign o_byte_count = r_count;

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed + randomized bench for xor_stream_descrambler with a cycle-level
// behavioural reference model of the handshake and keystream.
module tb_xor_stream_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] byte_count;

  always #5 clk = ~clk;

  xor_stream_descrambler dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_seed_load  (seed_load),
    .i_seed       (seed),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_byte_count (byte_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [15:0] e_lfsr;
  logic        e_mvalid;
  logic [7:0]  e_mdata;
  logic [15:0] e_cnt;
  logic        e_resync;

  function automatic logic [15:0] step8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = t[0] ? ((t >> 1) ^ 16'hB400) : (t >> 1);
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    e_lfsr   = 16'hACE1;
    e_mvalid = 1'b0;
    e_mdata  = 8'h00;
    e_cnt    = 16'h0;
    e_resync = 1'b0;
  endtask

  // Called at a falling edge: check registered outputs, drive one cycle of
  // inputs, check s_ready, advance the model, wait for the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic mr,
                      input logic sl, input logic [15:0] sd, output logic acc);
    logic exp_ready;
    chk("m_valid", m_valid, e_mvalid);
    if (e_mvalid) chk("m_data", m_data, e_mdata);
    chk("byte_count", byte_count, e_cnt);
    s_valid   = v;
    s_data    = d;
    m_ready   = mr;
    seed_load = sl;
    seed      = sd;
    #1;
    exp_ready = !e_resync && !sl && (!e_mvalid || mr);
    chk("s_ready", s_ready, exp_ready);
    acc = v && exp_ready;
    if (sl) begin
      e_lfsr   = (sd == 16'h0) ? 16'hACE1 : sd;
      e_mvalid = 1'b0;
      e_cnt    = 16'h0;
      e_resync = 1'b1;
    end else begin
      if (acc) begin
        e_mdata  = d ^ e_lfsr[7:0];
        e_mvalid = 1'b1;
        e_lfsr   = step8(e_lfsr);
        e_cnt    = e_cnt + 16'h1;
      end else if (mr) begin
        e_mvalid = 1'b0;
      end
      e_resync = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    s_valid   = 1'b0;
    s_data    = 8'h00;
    m_ready   = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [15:0] tx;
    logic [7:0]  p;
    logic        have;
    int          sent;

    quiet_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_count", byte_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Key after reset: E1, C4 both decode to 00
    step(1'b1, 8'hE1, 1'b1, 1'b0, 16'h0, acc);
    chk("key_b0", m_data, 8'h00);
    step(1'b1, 8'hC4, 1'b1, 1'b0, 16'h0, acc);
    chk("key_b1", m_data, 8'h00);
    chk("key_cnt2", byte_count, 16'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, acc);

    // Round trip after fresh reset
    quiet_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b1, 8'hB4, 1'b1, 1'b0, 16'h0, acc);
    chk("rt_55", m_data, 8'h55);
    tx   = step8(16'hACE1);
    have = 1'b0;
    p    = 8'h00;
    sent = 0;
    for (int cyc = 0; cyc < 3000 && sent < 256; cyc++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        p    = 8'($urandom);
        have = 1'b1;
      end
      step(have, p ^ tx[7:0], ($urandom_range(0, 2) != 0), 1'b0, 16'h0, acc);
      if (acc) begin
        chk("rt_plain", m_data, p);
        tx   = step8(tx);
        have = 1'b0;
        sent++;
      end
    end
    chk("rt_sent", sent, 256);

    // Backpressure: one byte accepted, then held stable
    step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, acc);
    step(1'b1, 8'h11, 1'b0, 1'b0, 16'h0, acc);
    chk("bp_first_acc", acc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h22, 1'b0, 1'b0, 16'h0, acc);
      chk("bp_ready_low", s_ready, 1'b0);
    end
    step(1'b1, 8'h22, 1'b1, 1'b0, 16'h0, acc);
    chk("bp_resume_acc", acc, 1'b1);

    // Resync mid-stream with a held output byte
    step(1'b1, 8'h33, 1'b0, 1'b0, 16'h0, acc);
    step(1'b1, 8'h33, 1'b0, 1'b1, 16'hACE1, acc);
    chk("rs_drop_valid", m_valid, 1'b0);
    chk("rs_count0", byte_count, 16'h0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 16'h0, acc);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 16'h0, acc);
    chk("rs_key", m_data, 8'h00);
    chk("rs_count1", byte_count, 16'd1);

    // Zero seed acts as default seed
    step(1'b0, 8'h00, 1'b1, 1'b1, 16'h0000, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, acc);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 16'h0, acc);
    chk("zs_key", m_data, 8'h00);

    // Back-to-back seed loads, then a random-seed byte
    step(1'b1, 8'h5A, 1'b1, 1'b1, 16'h1234, acc);
    step(1'b1, 8'h5A, 1'b1, 1'b1, 16'h5678, acc);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 16'h0, acc);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 16'h0, acc);
    chk("dbl_seed_key", m_data, 8'h5A ^ 8'h78);

    // Asynchronous reset while holding a byte
    step(1'b1, 8'h55, 1'b0, 1'b0, 16'h0, acc);
    chk("ar_held_valid", m_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_m_valid", m_valid, 1'b0);
    chk("ar_count", byte_count, 16'h0);
    chk("ar_s_ready", s_ready, 1'b0);
    @(negedge clk);
    quiet_inputs();
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'hE1, 1'b1, 1'b0, 16'h0, acc);
    chk("ar_key", m_data, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
